// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared types and helpers for the iterative multiply sequencer.
//               The MUL_EARLY_TERM_EN macro (used by mul_seq_ctrl) enables
//               early termination when the remaining multiplier is zero.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // ALU control encoding of the R-type multiply (funct 6'b011000)
  localparam logic [2:0] ALU_CTRL_MUL = 3'b111;

  // Number of RUN iterations needed to consume the whole multiplier
  function automatic int mul_steps(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_step_add.sv
`default_nettype none
// ============================================================================
// Module      : mul_step_add
// Description : One combinational shift-add step:
//               sum_o = acc_i + mcand_i * digit_i  (mod 2^WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_step_add
  import mul_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0]          acc_i,
  input  logic [WIDTH-1:0]          mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] digit_i,
  output logic [WIDTH-1:0]          sum_o
);

  // Add one shifted copy of the multiplicand per set digit bit; bits shifted
  // past WIDTH are dropped, which gives the mod 2^WIDTH truncation for free.
  always_comb begin
    sum_o = acc_i;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (digit_i[k]) begin
        sum_o = sum_o + (mcand_i << k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl
// Description : Iterative EX-stage multiply sequencer. Latches the operands,
//               runs a shift-add loop BITS_PER_CYCLE multiplier bits at a
//               time and stalls the pipeline until the low WIDTH product bits
//               are ready. Optional macro MUL_EARLY_TERM_EN ends the loop as
//               soon as the remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int                N        = mul_steps(WIDTH, BITS_PER_CYCLE);
  localparam int                CNT_W    = $clog2(N + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

  mul_state_t       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] step_sum;
  logic [WIDTH-1:0] mplier_shr;
  logic             last_step;

  mul_step_add #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .digit_i (mplier_q[BITS_PER_CYCLE-1:0]),
    .sum_o   (step_sum)
  );

  assign mplier_shr = mplier_q >> BITS_PER_CYCLE;

`ifdef MUL_EARLY_TERM_EN
  // Stop once no set multiplier bits remain; later steps would add zero
  assign last_step = (cnt_q == CNT_LAST) || (mplier_shr == '0);
`else
  assign last_step = (cnt_q == CNT_LAST);
`endif

  // Next-state and datapath update; flush overrides everything and keeps result
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          mcand_d  = src_a_i;
          mplier_d = src_b_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = step_sum;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_step) begin
          result_d = step_sum;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
    end
  end

  // Stall while accepting or iterating; released in DONE so EX/MEM captures result
  always_comb begin
    stall_o  = (((state_q == IDLE) && start_i) || (state_q == RUN)) && !flush_i && rst_i;
    busy_o   = (state_q != IDLE);
    done_o   = (state_q == DONE) && !flush_i;
    result_o = result_q;
  end

endmodule
`default_nettype wire
